// File: rtl/prewish_mask_arbiter_if.sv
// ----------------------------------------------------------------------------
// prewish_mask_arbiter_if
//  Bundles the two mask requesters and the blinky load port seen by
//  prewish_mask_arbiter.
//   master : requester/consumer side (drives strobes + masks, reads results)
//   slave  : arbiter side
//  Signals
//   i_stb0/i_dat0  req0 (mask sequencer) strobe + 8-bit mask
//   i_stb1/i_dat1  req1 (debug/test port) strobe + 8-bit mask
//   o_ack0/o_ack1  one-cycle issue pulses, coincide with o_stb
//   o_drop[1:0]    one-cycle pulse per requester: pending mask overwritten
//   o_stb/o_dat    load strobe + mask to blinky
//   o_busy         arbiter not idle or a request pending
// ----------------------------------------------------------------------------
interface prewish_mask_arbiter_if;
   logic       i_stb0;
   logic [7:0] i_dat0;
   logic       i_stb1;
   logic [7:0] i_dat1;
   logic       o_ack0;
   logic       o_ack1;
   logic [1:0] o_drop;
   logic       o_stb;
   logic [7:0] o_dat;
   logic       o_busy;

   modport master (
      output i_stb0, i_dat0, i_stb1, i_dat1,
      input  o_ack0, o_ack1, o_drop, o_stb, o_dat, o_busy
   );

   modport slave (
      input  i_stb0, i_dat0, i_stb1, i_dat1,
      output o_ack0, o_ack1, o_drop, o_stb, o_dat, o_busy
   );
endinterface

// File: rtl/prewish_mask_arbiter.sv
// ----------------------------------------------------------------------------
// prewish_mask_req
//  Per-requester front end: rising-edge detect on the strobe, one-deep mask
//  buffer with pending flag, and overwrite (drop) reporting.
//   i_clk/i_rst_n  clock, async active-low reset
//   i_stb/i_dat    requester strobe and mask
//   i_grant        arbiter is issuing this requester's buffer this cycle
//   o_pend         a mask is waiting
//   o_buf          buffered mask
//   o_drop         one-cycle pulse after a waiting mask was overwritten
// ----------------------------------------------------------------------------
module prewish_mask_req (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_stb,
   input  logic [7:0] i_dat,
   input  logic       i_grant,
   output logic       o_pend,
   output logic [7:0] o_buf,
   output logic       o_drop
);
   logic stb_q;
   logic rise;

   assign rise = i_stb & ~stb_q;

   // stb_q resets high so a strobe already high when reset releases is not
   // mistaken for a fresh request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stb_q  <= 1'b1;
         o_pend <= 1'b0;
         o_buf  <= 8'h00;
         o_drop <= 1'b0;
      end else begin
         stb_q  <= i_stb;
         // A new request arriving on the grant edge survives as the next one.
         if (rise)
            o_pend <= 1'b1;
         else if (i_grant)
            o_pend <= 1'b0;
         if (rise)
            o_buf <= i_dat;
         // The grant edge reads the old buffer, so a rise there loses nothing.
         o_drop <= rise & o_pend & ~i_grant;
      end
   end
endmodule

// ----------------------------------------------------------------------------
// prewish_mask_arbiter
//  Shares the blinky mask-load port between req0 (mask sequencer) and req1
//  (debug/test port). Requests are rising-edge qualified, arbitrated
//  round-robin on ties, issued as a one-cycle strobe, then followed by a
//  guard of GUARD_CYCLES clocks so blinky finishes latching.
//   GUARD_CYCLES   clocks spent in HOLD after each strobe (1..65535)
//   i_clk          system clock
//   i_rst_n        async active-low reset
//   bus            prewish_mask_arbiter_if.slave (requests, strobe, status)
//  Request edge seen at edge E0 -> o_stb high from E1 to E2; consecutive
//  strobes are at least GUARD_CYCLES+2 clocks apart.
// ----------------------------------------------------------------------------
module prewish_mask_arbiter #(
   parameter int GUARD_CYCLES = 16
) (
   input logic                   i_clk,
   input logic                   i_rst_n,
   prewish_mask_arbiter_if.slave bus
);
   localparam int NUM_REQ = 2;
   localparam int CW      = $clog2(GUARD_CYCLES + 1);
   localparam logic [CW-1:0] GUARD_M1 = CW'(GUARD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                        state, state_d;
   logic [CW-1:0]                 cnt;
   logic                          last_grant;
   logic                          win;
   logic [NUM_REQ-1:0]            grant;
   logic [NUM_REQ-1:0]            stb_v;
   logic [NUM_REQ-1:0]            pend;
   logic [NUM_REQ-1:0]            drop;
   logic [NUM_REQ-1:0][7:0]       dat_v;
   logic [NUM_REQ-1:0][7:0]       buf_v;
   logic [NUM_REQ-1:0]            ack_q;
   logic                          stb_q;
   logic [7:0]                    dat_q;
   logic                          busy_q;

   assign stb_v = {bus.i_stb1, bus.i_stb0};
   assign dat_v = {bus.i_dat1, bus.i_dat0};

   // ---------------------------------------------------------------- requesters
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      prewish_mask_req u_req (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_stb   (stb_v[g]),
         .i_dat   (dat_v[g]),
         .i_grant (grant[g]),
         .o_pend  (pend[g]),
         .o_buf   (buf_v[g]),
         .o_drop  (drop[g])
      );
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         state <= IDLE;
      else
         state <= state_d;
   end

   always_comb begin
      state_d = state;
      grant   = '0;
      win     = 1'b0;
      case (state)
         IDLE: begin
            if (|pend) begin
               // Tie goes to whoever was not served last; otherwise the sole
               // pending requester wins.
               win        = (&pend) ? ~last_grant : pend[1];
               grant[win] = 1'b1;
               state_d    = GRANT;
            end
         end
         GRANT:   state_d = HOLD;
         HOLD:    if (cnt == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stb_q      <= 1'b0;
         ack_q      <= '0;
         dat_q      <= 8'h00;
         last_grant <= 1'b1;
         cnt        <= '0;
         busy_q     <= 1'b0;
      end else begin
         stb_q <= |grant;
         ack_q <= grant;
         if (|grant) begin
            dat_q      <= buf_v[win];
            last_grant <= win;
         end
         // Loaded on the way into HOLD; HOLD then lasts GUARD_CYCLES clocks.
         if (state == GRANT)
            cnt <= GUARD_M1;
         else if (state == HOLD && cnt != '0)
            cnt <= cnt - 1'b1;
         // Current pend (not next) makes busy rise the edge after a request
         // lands; next state makes it drop on the very edge leaving HOLD.
         busy_q <= (state_d != IDLE) | (|pend);
      end
   end

   assign bus.o_stb  = stb_q;
   assign bus.o_dat  = dat_q;
   assign bus.o_ack0 = ack_q[0];
   assign bus.o_ack1 = ack_q[1];
   assign bus.o_drop = drop;
   assign bus.o_busy = busy_q;
endmodule
